pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
Central hazard and stall controller for the 5-stage pipeline. Generates load-enable and clear controls for the PC and the IF/ID, ID/EXE, EXE/MEM and MEM/WB stage registers. Sources are data hazards, taken branches resolved in EXE, and multi-cycle data-memory accesses. Contains a memory-wait FSM with a timeout watchdog and a saturating stall-cycle counter.

Parameters:
REG_W, 4, register-index width
CNT_W, 16, stall counter width
MEM_TIMEOUT, 255, maximum consecutive MEM_WAIT cycles before error

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
id_src1  in  REG_W  ID-stage source register 1
id_src2  in  REG_W  ID-stage source register 2
id_two_src  in  1  instruction in ID reads id_src2
id_valid  in  1  ID holds a real instruction
fwd_en  in  1  forwarding unit enabled
exe_wb_en  in  1  EXE instruction writes back
exe_mem_r_en  in  1  EXE instruction is a load
exe_dest  in  REG_W  EXE destination
mem_wb_en  in  1  MEM instruction writes back
mem_dest  in  REG_W  MEM destination
branch_taken  in  1  EXE resolved a taken branch
mem_req  in  1  MEM stage is accessing data memory
mem_ready  in  1  data memory completes this cycle
pc_ld, if_reg_ld, id_reg_ld, exe_reg_ld, mem_reg_ld  out  1 each  stage-register load enables
if_reg_clr, id_reg_clr  out  1 each  synchronous clears (bubble insert) for IF/ID and ID/EXE
hazard  out  1  data-hazard stall active this cycle
mem_err  out  1  sticky memory-timeout error
stall_cnt  out  CNT_W  saturating count of cycles with pc_ld=0

Behaviour:
- Reset (async, while rst=1):
  - state=RUN, wait_cnt=0, stall_cnt=0, mem_err=0.
  - All *_ld=0, all *_clr=0, hazard=0.
- Combinational terms:
  - src_match_e = exe_wb_en & (exe_dest==id_src1 | (id_two_src & exe_dest==id_src2)).
  - src_match_m: same form using mem_wb_en and mem_dest.
  - Data hazard, with fwd_en=1: raw_haz = id_valid & src_match_e & exe_mem_r_en (load-use only).
  - Data hazard, with fwd_en=0: raw_haz = id_valid & (src_match_e | src_match_m).
  - mem_stall = mem_req & ~mem_ready.
- Control priority, evaluated every cycle:
  1. mem_stall or mem_err: all *_ld=0, all *_clr=0, hazard=0. The full pipeline freezes; a pending branch_taken is held in EXE and acted on after release.
  2. branch_taken: all *_ld=1, if_reg_clr=1, id_reg_clr=1, hazard=0. This overrides raw_haz.
  3. raw_haz: pc_ld=0, if_reg_ld=0, id_reg_ld=1, id_reg_clr=1 (bubble into EXE), exe_reg_ld=1, mem_reg_ld=1, hazard=1.
  4. Otherwise: all *_ld=1, all *_clr=0.
- Control outputs are combinational, with zero-cycle latency from inputs.
- FSM, registered:
  - RUN -> MEM_WAIT when mem_stall; wait_cnt<=1.
  - MEM_WAIT, mem_ready=1 -> RUN; wait_cnt<=0.
  - MEM_WAIT, mem_req=0 -> RUN (request withdrawn).
  - MEM_WAIT, still stalled -> wait_cnt+1; when wait_cnt==MEM_TIMEOUT -> ERR, mem_err<=1.
  - ERR is absorbing until rst; pipeline frozen per rule 1.
- A memory access with mem_ready=1 in its first cycle causes no stall and no state change.
- stall_cnt increments on every cycle with pc_ld=0 and rst=0. It saturates at all-ones and does not wrap.
- Register index 0 is not special; matches on any index including 0.
- A new mem_req arriving in the same cycle the FSM returns to RUN is evaluated next cycle as a fresh request.

Test Plan:
- Load-use stall: fwd_en=1, exe_mem_r_en=1, exe_wb_en=1, exe_dest=3, id_src1=3, id_valid=1 -> hazard=1, pc_ld=0, if_reg_ld=0, id_reg_clr=1 for one cycle; stall_cnt=1.
- No forwarding: fwd_en=0, mem_wb_en=1, mem_dest=5, id_two_src=1, id_src2=5 -> hazard=1. Same case with id_two_src=0 -> hazard=0.
- Branch vs hazard: branch_taken=1 and raw_haz=1 in the same cycle -> if_reg_clr=1, id_reg_clr=1, all ld=1, hazard=0.
- Memory wait: mem_req=1, mem_ready=0 for 4 cycles then mem_ready=1 -> all ld=0 for 4 cycles, state MEM_WAIT, back in RUN after the ready cycle; stall_cnt=4. Repeat with branch_taken=1 throughout -> flush only on the ready cycle.
- Timeout: MEM_TIMEOUT=8, mem_req=1, mem_ready held 0 -> mem_err=1 after the 8th wait cycle; stays 1 with mem_req=0 until rst pulse clears it.
- Async reset mid-MEM_WAIT: assert rst between clock edges -> all outputs 0, stall_cnt=0 immediately. After release, the first cycle with no hazards gives all ld=1.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: stage-register load/clear
// generation, memory-wait FSM with timeout watchdog, saturating stall counter.
module pipeline_ctrl #(
    parameter int REG_W       = 4,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_two_src,
    input  logic             id_valid,
    input  logic             fwd_en,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             mem_wb_en,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_ld,
    output logic             if_reg_ld,
    output logic             id_reg_ld,
    output logic             exe_reg_ld,
    output logic             mem_reg_ld,
    output logic             if_reg_clr,
    output logic             id_reg_clr,
    output logic             hazard,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                mem_err_q, mem_err_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

    logic src_match_e, src_match_m, raw_haz, mem_stall;

    always_comb begin
        src_match_e = exe_wb_en & ((exe_dest == id_src1) | (id_two_src & (exe_dest == id_src2)));
        src_match_m = mem_wb_en & ((mem_dest == id_src1) | (id_two_src & (mem_dest == id_src2)));
        // With forwarding only a load result is unavailable in time.
        raw_haz     = id_valid & (fwd_en ? (src_match_e & exe_mem_r_en)
                                         : (src_match_e | src_match_m));
        mem_stall   = mem_req & ~mem_ready;
    end

    always_comb begin
        pc_ld      = 1'b0;
        if_reg_ld  = 1'b0;
        id_reg_ld  = 1'b0;
        exe_reg_ld = 1'b0;
        mem_reg_ld = 1'b0;
        if_reg_clr = 1'b0;
        id_reg_clr = 1'b0;
        hazard     = 1'b0;
        if (rst || mem_stall || mem_err_q) begin
            // frozen: everything held, a pending branch waits in EXE
        end else if (branch_taken) begin
            {pc_ld, if_reg_ld, id_reg_ld, exe_reg_ld, mem_reg_ld} = '1;
            if_reg_clr = 1'b1;
            id_reg_clr = 1'b1;
        end else if (raw_haz) begin
            id_reg_ld  = 1'b1;
            id_reg_clr = 1'b1;
            exe_reg_ld = 1'b1;
            mem_reg_ld = 1'b1;
            hazard     = 1'b1;
        end else begin
            {pc_ld, if_reg_ld, id_reg_ld, exe_reg_ld, mem_reg_ld} = '1;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        case (state_q)
            RUN: if (mem_stall) begin
                state_d    = MEM_WAIT;
                wait_cnt_d = WAIT_W'(1);
            end
            MEM_WAIT: if (!mem_stall) begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end else if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT)) begin
                state_d   = ERR;
                mem_err_d = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
            ERR: state_d = ERR;
            default: state_d = RUN;
        endcase

        stall_cnt_d = stall_cnt_q;
        if (!pc_ld && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed vector table, multi-cycle memory/timeout/reset
// sequences, and randomized traffic against a rule-level reference model.
module tb_pipeline_ctrl;
    localparam int REG_W = 4;
    localparam int CNT_W = 4;
    localparam int TMO   = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk, rst;
    logic [REG_W-1:0] id_src1, id_src2, exe_dest, mem_dest;
    logic id_two_src, id_valid, fwd_en, exe_wb_en, exe_mem_r_en, mem_wb_en;
    logic branch_taken, mem_req, mem_ready;
    logic pc_ld, if_reg_ld, id_reg_ld, exe_reg_ld, mem_reg_ld, if_reg_clr, id_reg_clr;
    logic hazard, mem_err;
    logic [CNT_W-1:0] stall_cnt;

    pipeline_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src), .id_valid(id_valid),
        .fwd_en(fwd_en), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .exe_dest(exe_dest),
        .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_ld(pc_ld), .if_reg_ld(if_reg_ld), .id_reg_ld(id_reg_ld), .exe_reg_ld(exe_reg_ld),
        .mem_reg_ld(mem_reg_ld), .if_reg_clr(if_reg_clr), .id_reg_clr(id_reg_clr),
        .hazard(hazard), .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [REG_W-1:0] src1, src2, exe_dest, mem_dest;
        logic two_src, valid, fwd, exe_wb, exe_rd, mem_wb, br, mem_req, mem_ready;
    } in_t;

    typedef struct packed {
        in_t        in;
        logic [7:0] exp;   // {pc,if,id,exe,mem ld, if_clr, id_clr, hazard}
    } vec_t;

    localparam logic [7:0] C_FREEZE = 8'b00000000;
    localparam logic [7:0] C_FLUSH  = 8'b11111110;
    localparam logic [7:0] C_BUBBLE = 8'b00111011;
    localparam logic [7:0] C_RUN    = 8'b11111000;

    int checks = 0;
    int errors = 0;

    // model state: consecutive stalled cycles, sticky error, stall count
    int m_n, m_cnt;
    bit m_err;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] ctrl_now();
        return {pc_ld, if_reg_ld, id_reg_ld, exe_reg_ld, mem_reg_ld, if_reg_clr, id_reg_clr, hazard};
    endfunction

    function automatic logic [7:0] model_ctrl(input in_t v, input bit err);
        bit me, mm, haz;
        me  = v.exe_wb && (v.exe_dest == v.src1 || (v.two_src && v.exe_dest == v.src2));
        mm  = v.mem_wb && (v.mem_dest == v.src1 || (v.two_src && v.mem_dest == v.src2));
        haz = v.valid && (v.fwd ? (me && v.exe_rd) : (me || mm));
        if ((v.mem_req && !v.mem_ready) || err) return C_FREEZE;
        if (v.br) return C_FLUSH;
        if (haz) return C_BUBBLE;
        return C_RUN;
    endfunction

    task automatic drive(input in_t v);
        id_src1 = v.src1; id_src2 = v.src2; exe_dest = v.exe_dest; mem_dest = v.mem_dest;
        id_two_src = v.two_src; id_valid = v.valid; fwd_en = v.fwd; exe_wb_en = v.exe_wb;
        exe_mem_r_en = v.exe_rd; mem_wb_en = v.mem_wb; branch_taken = v.br;
        mem_req = v.mem_req; mem_ready = v.mem_ready;
    endtask

    // Called at posedge+1; drives, checks before the next edge, advances the model.
    task automatic step(input in_t v, input logic [7:0] exp, input bit use_exp, input string nm);
        logic [7:0] m;
        drive(v);
        #2;
        m = model_ctrl(v, m_err);
        chk({nm, "_ctrl"}, 32'(ctrl_now()), 32'(use_exp ? exp : m));
        chk({nm, "_stall_cnt"}, 32'(stall_cnt), 32'(m_cnt));
        chk({nm, "_mem_err"}, 32'(mem_err), 32'(m_err));
        @(posedge clk);
        if (!m_err) begin
            if (v.mem_req && !v.mem_ready) begin
                m_n++;
                if (m_n > TMO) m_err = 1'b1;
            end else begin
                m_n = 0;
            end
        end
        if (!m[7] && m_cnt < CMAX) m_cnt++;
        #1;
    endtask

    // Asynchronous reset asserted between clock edges, outputs checked immediately.
    task automatic arst();
        #2 rst = 1'b1;
        #1;
        chk("rst_ctrl", 32'(ctrl_now()), 32'(C_FREEZE));
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_mem_err", 32'(mem_err), 32'd0);
        drive('0);
        @(posedge clk);
        #2 rst = 1'b0;
        m_n = 0; m_cnt = 0; m_err = 1'b0;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[8];
    in_t  v, stl, rdy;

    initial begin
        rst = 1'b1;
        drive('0);
        m_n = 0; m_cnt = 0; m_err = 1'b0;
        #3;
        chk("reset_ctrl", 32'(ctrl_now()), 32'(C_FREEZE));
        chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("reset_mem_err", 32'(mem_err), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        // load-use with forwarding
        tbl[0] = '{in: '{src1:3, src2:0, exe_dest:3, mem_dest:0, two_src:0, valid:1, fwd:1,
                   exe_wb:1, exe_rd:1, mem_wb:0, br:0, mem_req:0, mem_ready:0}, exp: C_BUBBLE};
        // no forwarding, MEM match on src2
        tbl[1] = '{in: '{src1:1, src2:5, exe_dest:0, mem_dest:5, two_src:1, valid:1, fwd:0,
                   exe_wb:0, exe_rd:0, mem_wb:1, br:0, mem_req:0, mem_ready:0}, exp: C_BUBBLE};
        // same but src2 not read
        tbl[2] = '{in: '{src1:1, src2:5, exe_dest:0, mem_dest:5, two_src:0, valid:1, fwd:0,
                   exe_wb:0, exe_rd:0, mem_wb:1, br:0, mem_req:0, mem_ready:0}, exp: C_RUN};
        // forwarding covers non-load EXE match
        tbl[3] = '{in: '{src1:3, src2:0, exe_dest:3, mem_dest:3, two_src:0, valid:1, fwd:1,
                   exe_wb:1, exe_rd:0, mem_wb:1, br:0, mem_req:0, mem_ready:0}, exp: C_RUN};
        // branch overrides load-use
        tbl[4] = '{in: '{src1:3, src2:0, exe_dest:3, mem_dest:0, two_src:0, valid:1, fwd:1,
                   exe_wb:1, exe_rd:1, mem_wb:0, br:1, mem_req:0, mem_ready:0}, exp: C_FLUSH};
        // register 0 matches like any other
        tbl[5] = '{in: '{src1:0, src2:7, exe_dest:0, mem_dest:9, two_src:0, valid:1, fwd:0,
                   exe_wb:1, exe_rd:0, mem_wb:0, br:0, mem_req:0, mem_ready:0}, exp: C_BUBBLE};
        // no real instruction in ID
        tbl[6] = '{in: '{src1:3, src2:0, exe_dest:3, mem_dest:0, two_src:0, valid:0, fwd:1,
                   exe_wb:1, exe_rd:1, mem_wb:0, br:0, mem_req:0, mem_ready:0}, exp: C_RUN};
        // memory ready in first cycle: no stall
        tbl[7] = '{in: '{src1:1, src2:2, exe_dest:4, mem_dest:6, two_src:1, valid:1, fwd:0,
                   exe_wb:1, exe_rd:0, mem_wb:1, br:0, mem_req:1, mem_ready:1}, exp: C_RUN};

        for (int i = 0; i < 8; i++) step(tbl[i].in, tbl[i].exp, 1'b1, $sformatf("vec%0d", i));

        // memory wait: 4 stalled cycles then ready
        arst();
        stl = '0; stl.mem_req = 1'b1;
        rdy = stl; rdy.mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) step(stl, C_FREEZE, 1'b1, "memwait");
        step(rdy, C_RUN, 1'b1, "memwait_ready");
        chk("memwait_stall_cnt4", 32'(stall_cnt), 32'd4);

        // same with branch held in EXE: flush only on the ready cycle
        arst();
        stl.br = 1'b1; rdy.br = 1'b1;
        for (int i = 0; i < 4; i++) step(stl, C_FREEZE, 1'b1, "memwait_br");
        step(rdy, C_FLUSH, 1'b1, "memwait_br_ready");
        stl.br = 1'b0;

        // timeout: error after the 8th cycle spent in MEM_WAIT
        arst();
        for (int i = 0; i < TMO; i++) step(stl, C_FREEZE, 1'b1, "tmo");
        chk("tmo_not_yet", 32'(mem_err), 32'd0);
        step(stl, C_FREEZE, 1'b1, "tmo_last");
        chk("tmo_err_set", 32'(mem_err), 32'd1);
        for (int i = 0; i < 12; i++) step('0, C_FREEZE, 1'b1, "tmo_sticky");
        chk("tmo_err_sticky", 32'(mem_err), 32'd1);
        chk("stall_cnt_saturated", 32'(stall_cnt), 32'(CMAX));
        arst();
        chk("tmo_err_cleared", 32'(mem_err), 32'd0);

        // async reset in the middle of MEM_WAIT
        for (int i = 0; i < 3; i++) step(stl, C_FREEZE, 1'b1, "mid_wait");
        drive(stl);
        arst();
        step('0, C_RUN, 1'b1, "after_reset");

        // randomized traffic vs model, with periodic resets and ready-starved phases
        for (int i = 0; i < 600; i++) begin
            if (i % 60 == 59) arst();
            v.src1 = REG_W'($urandom_range(0, 3));
            v.src2 = REG_W'($urandom_range(0, 3));
            v.exe_dest = REG_W'($urandom_range(0, 3));
            v.mem_dest = REG_W'($urandom_range(0, 3));
            v.two_src = 1'($urandom_range(0, 1));
            v.valid = 1'($urandom_range(0, 3) != 0);
            v.fwd = 1'($urandom_range(0, 1));
            v.exe_wb = 1'($urandom_range(0, 1));
            v.exe_rd = 1'($urandom_range(0, 1));
            v.mem_wb = 1'($urandom_range(0, 1));
            v.br = 1'($urandom_range(0, 3) == 0);
            v.mem_req = 1'($urandom_range(0, 2) != 0);
            v.mem_ready = ((i / 60) % 2 == 1) ? 1'($urandom_range(0, 7) == 0)
                                              : 1'($urandom_range(0, 1));
            step(v, 8'h00, 1'b0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
